lv_hv_mirror: RTL and testbench
===============================

LV_HV_MIRROR -- requirements
Module: lv_hv_mirror

Interface
REQ-001 CH_NUM, 2, number of mirrored ADC channels (legal 1..8).
REQ-002 ADC_DW, 10, ADC result width; legal range REG_DW < ADC_DW <= 2*REG_DW.
REQ-003 REG_DW, 8, HV register data width.
REQ-004 REG_AW, 7, HV register address width.
REQ-005 BASE_ADDR, 7'h10, address of the channel 0 low byte; channel n uses BASE_ADDR+2n (low) and BASE_ADDR+2n+1 (high).
REQ-006 POLL_CYC, 1000, idle cycles between sweeps (>=1).
REQ-007 TMO_CYC, 64, maximum cycles a request waits for ack (>=2).
REQ-008 i_clk  input  1  core clock; the block uses one clock.
REQ-009 i_rst_n  input  1  reset; synchronous and active-low.
REQ-010 i_mirror_en  input  1  level; enables periodic polling.
REQ-011 i_err_clr  input  1  one-cycle pulse; clears all sticky error bits.
REQ-012 o_rd_req  output  1  read request to the HV register path.
REQ-013 o_rd_addr  output  REG_AW  read address; valid while o_rd_req=1.
REQ-014 i_rd_ack  input  1  one-cycle read acknowledge.
REQ-015 i_rd_data  input  REG_DW  read data; qualified by i_rd_ack.
REQ-016 i_rd_err  input  1  CRC error flag; qualified by i_rd_ack.
REQ-017 o_adc_data  output  CH_NUM*ADC_DW  packed results; channel 0 in the LSBs.
REQ-018 o_adc_upd  output  CH_NUM  per-channel one-cycle update strobe.
REQ-019 o_busy  output  1  high in every state except IDLE.
REQ-020 o_tmo_err / o_crc_err  output  CH_NUM each  sticky per-channel error flags.

Function
REQ-021 FSM states: IDLE, REQ_LO, REQ_HI, COMMIT, INTVL.
REQ-022 IDLE: i_mirror_en=1 -> REQ_LO with ch=0; the first sweep starts with no interval wait.
REQ-023 REQ_LO/REQ_HI: o_rd_req=1 and o_rd_addr=BASE_ADDR+2*ch (+1 in REQ_HI); the address is stable while the request is high.
REQ-024 Handshake: o_rd_req deasserts the cycle after i_rd_ack, and stays low for at least one cycle between requests.
REQ-025 REQ_LO: ack with no error -> latch low byte, go to REQ_HI.
REQ-026 REQ_HI: ack with no error -> latch high byte, go to COMMIT.
REQ-027 Ack with i_rd_err=1 in REQ_LO or REQ_HI -> set o_crc_err[ch], abandon the pair, advance channel.
REQ-028 TMO_CYC cycles in REQ_LO/REQ_HI without ack -> drop the request, set o_tmo_err[ch], advance channel; if ack and expiry coincide, the ack wins.
REQ-029 COMMIT (one cycle): the channel ch slice of o_adc_data loads {hi[ADC_DW-REG_DW-1:0], lo} and o_adc_upd[ch] pulses high for exactly one cycle, both on the edge leaving COMMIT; the block then advances channel.
REQ-030 Advance: if ch<CH_NUM-1 -> ch+1, REQ_LO; else ch=0, load interval counter, INTVL.
REQ-031 INTVL: count POLL_CYC cycles, then go to REQ_LO.
REQ-032 i_mirror_en=0 in INTVL -> IDLE on the next edge. i_mirror_en=0 in REQ_LO/REQ_HI/COMMIT -> finish the current pair (commit or error), then go to IDLE.
REQ-033 A failed pair never partially updates o_adc_data; the last good value holds.
REQ-034 An ack outside REQ_LO/REQ_HI (late ack) is ignored.
REQ-035 Unused high-byte bits are discarded.
REQ-036 An error set and i_err_clr in the same cycle -> the set wins.

Reset
REQ-037 While i_rst_n=0 at the clock edge: state=IDLE, ch=0, all counters 0, o_rd_req=0, o_rd_addr=0, o_adc_data=0, o_adc_upd=0, o_busy=0, all error flags 0.
REQ-038 Reset mid-transaction abandons the request immediately, and no update strobe is issued.

Structure
REQ-039 Shared package lv_param holds the ADC_DW/REG_DW/REG_AW defaults and the typedef lv_mirror_state_e.
REQ-040 One sub-module, lv_cyc_cnt (loadable down counter with a zero flag), is instantiated once and reused for both the interval count and the timeout count.

Verification
REQ-041 Scenario: CH_NUM=2, enable, acks data 8'hA5/8'h03 for ch0 and 8'h11/8'h02 for ch1 -> ch0=10'h3A5, ch1=10'h211, one upd pulse per channel, then INTVL for 1000 cycles.
REQ-042 Scenario: ch1 low-byte ack with i_rd_err=1 -> o_crc_err=2'b10, ch1 data unchanged, no upd[1], sweep continues.
REQ-043 Scenario: withhold ack on ch0 high byte -> req drops after 64 cycles, o_tmo_err[0]=1, a late ack is ignored, ch1 is polled next.
REQ-044 Scenario: deassert i_mirror_en during ch0 REQ_HI -> ch0 commits, then IDLE, o_busy=0, no ch1 request.
REQ-045 Scenario: assert i_err_clr in the same cycle as a new timeout -> the flag stays 1; i_err_clr alone -> all flags 0.
REQ-046 Scenario: reset asserted while o_rd_req=1 -> all outputs 0 on the next edge, and on re-enable the sweep restarts at ch0.

Source files
------------

// File: rtl/lv_hv_mirror_pkg.sv
// Shared defaults and the state type for the LV-side mirror of HV ADC results.
package lv_param;

  localparam int LV_ADC_DW = 10;
  localparam int LV_REG_DW = 8;
  localparam int LV_REG_AW = 7;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ_LO,
    ST_REQ_HI,
    ST_COMMIT,
    ST_INTVL
  } lv_mirror_state_e;

  function automatic int lv_max(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/lv_hv_mirror_cyc_cnt.sv
// Loadable down counter with a zero flag; the mirror shares one instance
// between the poll interval and the ack timeout, which never overlap.
module lv_cyc_cnt #(
  parameter int W = 10
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         zero
);

  logic [W-1:0] cnt;

  // load has priority; decrement saturates at zero
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (dec && (cnt != '0)) begin
      cnt <= cnt - W'(1);
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/lv_hv_mirror.sv
// Periodically reads low/high result bytes of each HV ADC channel over the
// register read path and mirrors the assembled values on the LV side.
module lv_hv_mirror
  import lv_param::*;
#(
  parameter int                CH_NUM    = 2,
  parameter int                ADC_DW    = LV_ADC_DW,
  parameter int                REG_DW    = LV_REG_DW,
  parameter int                REG_AW    = LV_REG_AW,
  parameter logic [REG_AW-1:0] BASE_ADDR = 'h10,
  parameter int                POLL_CYC  = 1000,
  parameter int                TMO_CYC   = 64
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_mirror_en,
  input  logic                     i_err_clr,
  output logic                     o_rd_req,
  output logic [REG_AW-1:0]        o_rd_addr,
  input  logic                     i_rd_ack,
  input  logic [REG_DW-1:0]        i_rd_data,
  input  logic                     i_rd_err,
  output logic [CH_NUM*ADC_DW-1:0] o_adc_data,
  output logic [CH_NUM-1:0]        o_adc_upd,
  output logic                     o_busy,
  output logic [CH_NUM-1:0]        o_tmo_err,
  output logic [CH_NUM-1:0]        o_crc_err
);

  localparam int CHW  = (CH_NUM > 1) ? $clog2(CH_NUM) : 1;
  localparam int HIW  = ADC_DW - REG_DW;
  localparam int CNTW = $clog2(lv_max(POLL_CYC, TMO_CYC) + 1);
  localparam logic [CHW-1:0] LAST_CH = CHW'(CH_NUM - 1);

  lv_mirror_state_e  state;
  logic [CHW-1:0]    ch;
  logic [REG_DW-1:0] lo_byte;
  logic [HIW-1:0]    hi_byte;

  logic              in_req;
  logic              ack_ok;
  logic              ack_good;
  logic              ack_bad;
  logic              tmo_hit;
  logic              raise;
  logic              pair_end;
  logic              go_intvl;
  logic              cnt_load;
  logic              cnt_dec;
  logic              cnt_zero;
  logic [CNTW-1:0]   cnt_val;
  logic [CH_NUM-1:0] ch_onehot;
  logic [REG_AW-1:0] req_addr;

  // Handshake events and shared-counter control. An ack only counts while
  // the request is actually high, so late acks are dropped; the request is
  // raised one cycle after entering a request state, which guarantees the
  // low gap between consecutive requests.
  always_comb begin
    in_req    = (state == ST_REQ_LO) || (state == ST_REQ_HI);
    ack_ok    = in_req && o_rd_req && i_rd_ack;
    ack_good  = ack_ok && !i_rd_err;
    ack_bad   = ack_ok && i_rd_err;
    tmo_hit   = in_req && o_rd_req && !i_rd_ack && cnt_zero;
    raise     = in_req && !o_rd_req;
    pair_end  = ack_bad || tmo_hit || (state == ST_COMMIT);
    go_intvl  = pair_end && i_mirror_en && (ch == LAST_CH);
    cnt_load  = raise || go_intvl;
    cnt_val   = go_intvl ? CNTW'(POLL_CYC - 1) : CNTW'(TMO_CYC - 1);
    cnt_dec   = (in_req && o_rd_req) || (state == ST_INTVL);
    ch_onehot = CH_NUM'(1) << ch;
    req_addr  = BASE_ADDR + REG_AW'({ch, 1'b0}) + REG_AW'(state == ST_REQ_HI);
  end

  lv_cyc_cnt #(
    .W(CNTW)
  ) u_cyc_cnt (
    .clk      (i_clk),
    .rst_n    (i_rst_n),
    .load     (cnt_load),
    .load_val (cnt_val),
    .dec      (cnt_dec),
    .zero     (cnt_zero)
  );

  // Sweep FSM with registered request, result and error outputs
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state      <= ST_IDLE;
      ch         <= '0;
      lo_byte    <= '0;
      hi_byte    <= '0;
      o_rd_req   <= 1'b0;
      o_rd_addr  <= '0;
      o_adc_data <= '0;
      o_adc_upd  <= '0;
      o_tmo_err  <= '0;
      o_crc_err  <= '0;
    end else begin
      o_adc_upd <= '0;
      // a new error in the same cycle as a clear still sets its flag
      o_tmo_err <= (o_tmo_err & ~{CH_NUM{i_err_clr}}) | (tmo_hit ? ch_onehot : '0);
      o_crc_err <= (o_crc_err & ~{CH_NUM{i_err_clr}}) | (ack_bad ? ch_onehot : '0);

      if (raise) begin
        o_rd_req  <= 1'b1;
        o_rd_addr <= req_addr;
      end
      if (ack_ok || tmo_hit) begin
        o_rd_req <= 1'b0;
      end

      case (state)
        ST_IDLE: begin
          if (i_mirror_en) begin
            state <= ST_REQ_LO;
            ch    <= '0;
          end
        end
        ST_REQ_LO: begin
          if (ack_good) begin
            lo_byte <= i_rd_data;
            state   <= ST_REQ_HI;
          end
        end
        ST_REQ_HI: begin
          if (ack_good) begin
            hi_byte <= i_rd_data[HIW-1:0];
            state   <= ST_COMMIT;
          end
        end
        ST_COMMIT: begin
          o_adc_data[ch*ADC_DW +: ADC_DW] <= {hi_byte, lo_byte};
          o_adc_upd                       <= ch_onehot;
        end
        ST_INTVL: begin
          if (!i_mirror_en) begin
            state <= ST_IDLE;
          end else if (cnt_zero) begin
            state <= ST_REQ_LO;
          end
        end
        default: state <= ST_IDLE;
      endcase

      // channel advance after a commit or an abandoned pair
      if (pair_end) begin
        if (!i_mirror_en) begin
          state <= ST_IDLE;
          ch    <= '0;
        end else if (ch == LAST_CH) begin
          state <= ST_INTVL;
          ch    <= '0;
        end else begin
          state <= ST_REQ_LO;
          ch    <= ch + CHW'(1);
        end
      end
    end
  end

  assign o_busy = (state != ST_IDLE);

endmodule

// File: tb/tb_lv_hv_mirror.sv
// Scoreboard bench for lv_hv_mirror: a bench-side responder serves read
// requests, expected commits are queued at hi-byte ack time and popped when
// an update strobe appears.
module tb_lv_hv_mirror;

  localparam int CH_NUM   = 2;
  localparam int ADC_DW   = 10;
  localparam int REG_DW   = 8;
  localparam int REG_AW   = 7;
  localparam int POLL_CYC = 1000;
  localparam int TMO_CYC  = 64;

  logic                     i_clk;
  logic                     i_rst_n;
  logic                     i_mirror_en;
  logic                     i_err_clr;
  logic                     o_rd_req;
  logic [REG_AW-1:0]        o_rd_addr;
  logic                     i_rd_ack;
  logic [REG_DW-1:0]        i_rd_data;
  logic                     i_rd_err;
  logic [CH_NUM*ADC_DW-1:0] o_adc_data;
  logic [CH_NUM-1:0]        o_adc_upd;
  logic                     o_busy;
  logic [CH_NUM-1:0]        o_tmo_err;
  logic [CH_NUM-1:0]        o_crc_err;

  typedef struct {
    int              ch;
    logic [ADC_DW-1:0] val;
  } exp_t;

  exp_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   upd_cnt = 0;

  lv_hv_mirror #(
    .CH_NUM    (CH_NUM),
    .ADC_DW    (ADC_DW),
    .REG_DW    (REG_DW),
    .REG_AW    (REG_AW),
    .BASE_ADDR (7'h10),
    .POLL_CYC  (POLL_CYC),
    .TMO_CYC   (TMO_CYC)
  ) dut (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .i_mirror_en (i_mirror_en),
    .i_err_clr   (i_err_clr),
    .o_rd_req    (o_rd_req),
    .o_rd_addr   (o_rd_addr),
    .i_rd_ack    (i_rd_ack),
    .i_rd_data   (i_rd_data),
    .i_rd_err    (i_rd_err),
    .o_adc_data  (o_adc_data),
    .o_adc_upd   (o_adc_upd),
    .o_busy      (o_busy),
    .o_tmo_err   (o_tmo_err),
    .o_crc_err   (o_crc_err)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // every update strobe must match the oldest queued commit
  always @(negedge i_clk) begin
    if (i_rst_n && (o_adc_upd != '0)) begin
      if (exp_q.size() == 0) begin
        chk("upd_unexpected", 64'(o_adc_upd), 64'd0);
      end else begin
        exp_t e;
        logic [CH_NUM*ADC_DW-1:0] d;
        logic [CH_NUM-1:0] oh;
        e  = exp_q.pop_front();
        d  = o_adc_data;
        oh = CH_NUM'(1) << e.ch;
        chk("upd_ch", 64'(o_adc_upd), 64'(oh));
        chk("upd_data", 64'(d[e.ch*ADC_DW +: ADC_DW]), 64'(e.val));
        $display("[TB] upd ch=%0d data=%h", e.ch, d[e.ch*ADC_DW +: ADC_DW]);
        upd_cnt++;
      end
    end
  end

  task automatic wait_req(input logic [REG_AW-1:0] addr, output int n);
    n = 0;
    while (!o_rd_req && n < 3000) begin
      @(negedge i_clk);
      n++;
    end
    chk("req_seen", 64'(o_rd_req), 64'd1);
    if (o_rd_req) chk("rd_addr", 64'(o_rd_addr), 64'(addr));
  endtask

  task automatic serve(input logic [REG_AW-1:0] addr, input logic [7:0] data, input logic err);
    int n;
    wait_req(addr, n);
    i_rd_data = data;
    i_rd_err  = err;
    i_rd_ack  = 1'b1;
    @(negedge i_clk);
    i_rd_ack  = 1'b0;
    i_rd_err  = 1'b0;
    $display("[TB] rd addr=%h data=%h err=%b", addr, data, err);
    chk("req_drop", 64'(o_rd_req), 64'd0);
  endtask

  // withhold the ack, optionally clear errors on the expiry cycle, then send a late ack
  task automatic withhold(input logic [REG_AW-1:0] addr, input logic clr);
    int n;
    int hi_cnt;
    wait_req(addr, n);
    hi_cnt = 0;
    while (o_rd_req && hi_cnt < 200) begin
      hi_cnt++;
      if (clr && hi_cnt == TMO_CYC) i_err_clr = 1'b1;
      @(negedge i_clk);
      i_err_clr = 1'b0;
    end
    $display("[TB] rd addr=%h withheld for %0d cycles", addr, hi_cnt);
    chk("tmo_len", 64'(hi_cnt), 64'(TMO_CYC));
    i_rd_data = 8'hFF;
    i_rd_err  = 1'b1;
    i_rd_ack  = 1'b1;
    @(negedge i_clk);
    i_rd_ack  = 1'b0;
    i_rd_err  = 1'b0;
  endtask

  task automatic push(input int c, input logic [7:0] lo, input logic [7:0] hi);
    exp_t e;
    e.ch  = c;
    e.val = {hi[ADC_DW-REG_DW-1:0], lo};
    exp_q.push_back(e);
  endtask

  task automatic good_pair(input int c, input logic [7:0] lo, input logic [7:0] hi);
    serve(7'h10 + 7'(2*c), lo, 1'b0);
    push(c, lo, hi);
    serve(7'h11 + 7'(2*c), hi, 1'b0);
  endtask

  task automatic wait_upd();
    int n = 0;
    while (o_adc_upd == '0 && n < 10) begin
      @(negedge i_clk);
      n++;
    end
    chk("upd_seen", 64'(o_adc_upd != '0), 64'd1);
    @(negedge i_clk);
  endtask

  initial begin
    int n;
    int gap;
    int req_hi;
    i_rst_n     = 1'b0;
    i_mirror_en = 1'b0;
    i_err_clr   = 1'b0;
    i_rd_ack    = 1'b0;
    i_rd_data   = '0;
    i_rd_err    = 1'b0;
    repeat (3) @(negedge i_clk);

    // reset state
    chk("rst_req", 64'(o_rd_req), 64'd0);
    chk("rst_addr", 64'(o_rd_addr), 64'd0);
    chk("rst_data", 64'(o_adc_data), 64'd0);
    chk("rst_upd", 64'(o_adc_upd), 64'd0);
    chk("rst_busy", 64'(o_busy), 64'd0);
    chk("rst_err", 64'({o_tmo_err, o_crc_err}), 64'd0);
    i_rst_n = 1'b1;
    @(negedge i_clk);

    // sweep 1: normal pairs, first sweep starts without interval
    i_mirror_en = 1'b1;
    wait_req(7'h10, n);
    chk("first_no_wait", 64'(n <= 4), 64'd1);
    good_pair(0, 8'hA5, 8'h03);
    wait_upd();
    good_pair(1, 8'h11, 8'h02);
    wait_upd();
    chk("sweep1_data", 64'(o_adc_data), 64'({10'h211, 10'h3A5}));
    chk("sweep1_upds", 64'(upd_cnt), 64'd2);
    chk("intvl_busy", 64'(o_busy), 64'd1);
    gap = 1;
    while (!o_rd_req && gap < 3000) begin
      @(negedge i_clk);
      gap++;
    end
    $display("[TB] interval gap %0d cycles", gap);
    chk("intvl_gap_ok", 64'(gap >= POLL_CYC && gap <= POLL_CYC + 2), 64'd1);

    // sweep 2: CRC error on ch1 low byte
    good_pair(0, 8'h5A, 8'h01);
    wait_upd();
    serve(7'h12, 8'h99, 1'b1);
    repeat (3) @(negedge i_clk);
    chk("crc_flag", 64'(o_crc_err), 64'(2'b10));
    chk("crc_hold", 64'(o_adc_data), 64'({10'h211, 10'h15A}));
    chk("crc_no_upd", 64'(upd_cnt), 64'd3);

    // sweep 3: timeout on ch0 high byte, late ack ignored, ch1 next
    serve(7'h10, 8'h3C, 1'b0);
    withhold(7'h11, 1'b0);
    chk("tmo_flag", 64'(o_tmo_err), 64'(2'b01));
    good_pair(1, 8'h33, 8'h01);
    wait_upd();
    chk("late_ack_crc", 64'(o_crc_err), 64'(2'b10));
    chk("tmo_hold", 64'(o_adc_data), 64'({10'h133, 10'h15A}));

    // clear alone during the interval
    i_err_clr = 1'b1;
    @(negedge i_clk);
    i_err_clr = 1'b0;
    chk("clr_all", 64'({o_tmo_err, o_crc_err}), 64'd0);

    // sweep 4: clear coincides with a new timeout; unused high bits discarded
    serve(7'h10, 8'h44, 1'b0);
    withhold(7'h11, 1'b1);
    chk("set_wins", 64'(o_tmo_err), 64'(2'b01));
    good_pair(1, 8'h55, 8'hFB);
    wait_upd();
    chk("hi_discard", 64'(o_adc_data), 64'({10'h355, 10'h15A}));

    // sweep 5: disable during ch0 high byte, pair completes, then idle
    serve(7'h10, 8'h66, 1'b0);
    wait_req(7'h11, n);
    i_mirror_en = 1'b0;
    push(0, 8'h66, 8'h02);
    serve(7'h11, 8'h02, 1'b0);
    wait_upd();
    @(negedge i_clk);
    chk("dis_busy", 64'(o_busy), 64'd0);
    req_hi = 0;
    repeat (40) begin
      @(negedge i_clk);
      if (o_rd_req) req_hi++;
    end
    chk("dis_no_req", 64'(req_hi), 64'd0);
    chk("dis_data", 64'(o_adc_data), 64'({10'h355, 10'h266}));

    // reset while a request is pending, then restart at ch0
    i_mirror_en = 1'b1;
    wait_req(7'h10, n);
    i_rst_n = 1'b0;
    @(negedge i_clk);
    chk("mrst_req", 64'(o_rd_req), 64'd0);
    chk("mrst_addr", 64'(o_rd_addr), 64'd0);
    chk("mrst_data", 64'(o_adc_data), 64'd0);
    chk("mrst_busy", 64'(o_busy), 64'd0);
    chk("mrst_err", 64'({o_tmo_err, o_crc_err}), 64'd0);
    @(negedge i_clk);
    i_rst_n = 1'b1;
    good_pair(0, 8'h77, 8'h02);
    wait_upd();
    good_pair(1, 8'h88, 8'h01);
    wait_upd();
    chk("restart_data", 64'(o_adc_data), 64'({10'h188, 10'h277}));
    chk("queue_empty", 64'(exp_q.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
